ls_queue: RTL and testbench

LS_QUEUE -- requirements
Module: ls_queue

---
 rtl/ls_queue.sv | 188 ++++++++++++++++++
 tb/tb_ls_queue.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_queue.sv
// In-order load/store queue: circular buffer of pending memory ops with operand
// wakeup from two broadcast buses, store commit tracking and rollback.
module ls_queue #(
  parameter int DEPTH       = 16,
  parameter int ROB_W       = 4,
  parameter int XLEN        = 32,
  parameter int OPW         = 6,
  parameter int FULL_MARGIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             enable_sign_from_cmd,
  input  logic [OPW-1:0]   opnum_from_cmd,
  input  logic             is_store_from_cmd,
  input  logic [XLEN-1:0]  V1_from_cmd,
  input  logic [XLEN-1:0]  V2_from_cmd,
  input  logic [XLEN-1:0]  imm_from_cmd,
  input  logic [ROB_W-1:0] Q1_from_cmd,
  input  logic [ROB_W-1:0] Q2_from_cmd,
  input  logic [ROB_W-1:0] rob_id_from_cmd,
  input  logic             rollback_sign_from_rob,
  input  logic             commit_sign_from_rob,
  input  logic [ROB_W-1:0] rob_id_from_rob,
  input  logic             valid_sign_from_rs_ex,
  input  logic [ROB_W-1:0] rob_id_from_rs_ex,
  input  logic [XLEN-1:0]  data_from_rs_ex,
  input  logic             valid_sign_from_ls_ex,
  input  logic [ROB_W-1:0] rob_id_from_ls_ex,
  input  logic [XLEN-1:0]  data_from_ls_ex,
  input  logic             full_sign_from_ls_ex,
  output logic             enable_sign_to_ls_ex,
  output logic [OPW-1:0]   opnum_to_ls_ex,
  output logic [XLEN-1:0]  address_to_ls_ex,
  output logic [XLEN-1:0]  store_data_to_ls_ex,
  output logic [ROB_W-1:0] rob_id,
  output logic             full_sign_to_fch
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic             is_store;
    logic [OPW-1:0]   opnum;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic [XLEN-1:0]  imm;
    logic [ROB_W-1:0] q1;
    logic [ROB_W-1:0] q2;
    logic [ROB_W-1:0] rob_id;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d, committed_q, committed_d;
  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d, keep_cnt;
  logic             enable_q, enable_d;
  logic [OPW-1:0]   opnum_q, opnum_d;
  logic [XLEN-1:0]  address_q, address_d, store_data_q, store_data_d;
  logic [ROB_W-1:0] rob_id_q, rob_id_d;
  entry_t           head_ent, new_ent;
  logic             do_issue, do_enq;

  function automatic logic hit(input logic valid, input logic [ROB_W-1:0] tag,
                               input logic [ROB_W-1:0] q);
    return valid && (tag != '0) && (q == tag);
  endfunction

  // Replace any operand still waiting on a tag that is broadcast this cycle.
  function automatic entry_t wake(input entry_t e);
    entry_t r;
    r = e;
    if (hit(valid_sign_from_rs_ex, rob_id_from_rs_ex, r.q1)) begin r.v1 = data_from_rs_ex; r.q1 = '0; end
    if (hit(valid_sign_from_ls_ex, rob_id_from_ls_ex, r.q1)) begin r.v1 = data_from_ls_ex; r.q1 = '0; end
    if (hit(valid_sign_from_rs_ex, rob_id_from_rs_ex, r.q2)) begin r.v2 = data_from_rs_ex; r.q2 = '0; end
    if (hit(valid_sign_from_ls_ex, rob_id_from_ls_ex, r.q2)) begin r.v2 = data_from_ls_ex; r.q2 = '0; end
    return r;
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can leave a latch behind.
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    busy_d       = busy_q;
    committed_d  = committed_q;
    ent_d        = ent_q;
    enable_d     = rdy ? 1'b0 : enable_q;
    opnum_d      = opnum_q;
    address_d    = address_q;
    store_data_d = store_data_q;
    rob_id_d     = rob_id_q;

    keep_cnt = '0;
    for (int i = 0; i < DEPTH; i++) keep_cnt = keep_cnt + CW'(busy_q[i] & committed_q[i]);

    head_ent = ent_q[head_q];
    do_issue = busy_q[head_q] && !full_sign_from_ls_ex && (head_ent.q1 == '0) &&
               (!head_ent.is_store || ((head_ent.q2 == '0) && committed_q[head_q]));
    do_enq   = enable_sign_from_cmd && (count_q < CW'(DEPTH));

    new_ent.is_store = is_store_from_cmd;
    new_ent.opnum    = opnum_from_cmd;
    new_ent.v1       = V1_from_cmd;
    new_ent.v2       = V2_from_cmd;
    new_ent.imm      = imm_from_cmd;
    new_ent.q1       = Q1_from_cmd;
    new_ent.q2       = Q2_from_cmd;
    new_ent.rob_id   = rob_id_from_cmd;
    new_ent          = wake(new_ent);

    if (rdy) begin
      if (rollback_sign_from_rob) begin
        // Committed stores form a run starting at head, so keeping them in place is enough.
        busy_d      = busy_q & committed_q;
        committed_d = busy_q & committed_q;
        tail_d      = head_q + AW'(keep_cnt);
        count_d     = keep_cnt;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy_q[i]) begin
            ent_d[i] = wake(ent_q[i]);
            if (commit_sign_from_rob && ent_q[i].is_store && (ent_q[i].rob_id == rob_id_from_rob))
              committed_d[i] = 1'b1;
          end
        end
        if (do_issue) begin
          enable_d            = 1'b1;
          opnum_d             = head_ent.opnum;
          address_d           = head_ent.v1 + head_ent.imm;
          store_data_d        = head_ent.v2;
          rob_id_d            = head_ent.rob_id;
          busy_d[head_q]      = 1'b0;
          committed_d[head_q] = 1'b0;
          head_d              = head_q + AW'(1);
        end
        if (do_enq) begin
          ent_d[tail_q]       = new_ent;
          busy_d[tail_q]      = 1'b1;
          committed_d[tail_q] = 1'b0;
          tail_d              = tail_q + AW'(1);
        end
        count_d = count_q + CW'(do_enq) - CW'(do_issue);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      committed_q  <= '0;
      enable_q     <= 1'b0;
      opnum_q      <= '0;
      address_q    <= '0;
      store_data_q <= '0;
      rob_id_q     <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      committed_q  <= committed_d;
      enable_q     <= enable_d;
      opnum_q      <= opnum_d;
      address_q    <= address_d;
      store_data_q <= store_data_d;
      rob_id_q     <= rob_id_d;
    end
  end

  // NOTE: payload storage has no reset; busy_q alone decides whether a slot holds anything.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign enable_sign_to_ls_ex = enable_q;
  assign opnum_to_ls_ex       = opnum_q;
  assign address_to_ls_ex     = address_q;
  assign store_data_to_ls_ex  = store_data_q;
  assign rob_id               = rob_id_q;
  assign full_sign_to_fch     = (count_q >= CW'(DEPTH - FULL_MARGIN));

endmodule

// File: tb/tb_ls_queue.sv
// Bench for ls_queue: directed scenarios plus randomized traffic against a
// queue-based reference model of the load/store queue.
module tb_ls_queue;
  localparam int DEPTH = 16, ROB_W = 4, XLEN = 32, OPW = 6, FULL_MARGIN = 2;

  logic clk = 1'b0;
  logic rst, rdy;
  logic enable_sign_from_cmd, is_store_from_cmd;
  logic [OPW-1:0] opnum_from_cmd;
  logic [XLEN-1:0] V1_from_cmd, V2_from_cmd, imm_from_cmd;
  logic [ROB_W-1:0] Q1_from_cmd, Q2_from_cmd, rob_id_from_cmd;
  logic rollback_sign_from_rob, commit_sign_from_rob;
  logic [ROB_W-1:0] rob_id_from_rob;
  logic valid_sign_from_rs_ex, valid_sign_from_ls_ex, full_sign_from_ls_ex;
  logic [ROB_W-1:0] rob_id_from_rs_ex, rob_id_from_ls_ex;
  logic [XLEN-1:0] data_from_rs_ex, data_from_ls_ex;
  logic enable_sign_to_ls_ex, full_sign_to_fch;
  logic [OPW-1:0] opnum_to_ls_ex;
  logic [XLEN-1:0] address_to_ls_ex, store_data_to_ls_ex;
  logic [ROB_W-1:0] rob_id;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ls_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN), .OPW(OPW), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .enable_sign_from_cmd(enable_sign_from_cmd), .opnum_from_cmd(opnum_from_cmd),
    .is_store_from_cmd(is_store_from_cmd), .V1_from_cmd(V1_from_cmd), .V2_from_cmd(V2_from_cmd),
    .imm_from_cmd(imm_from_cmd), .Q1_from_cmd(Q1_from_cmd), .Q2_from_cmd(Q2_from_cmd),
    .rob_id_from_cmd(rob_id_from_cmd), .rollback_sign_from_rob(rollback_sign_from_rob),
    .commit_sign_from_rob(commit_sign_from_rob), .rob_id_from_rob(rob_id_from_rob),
    .valid_sign_from_rs_ex(valid_sign_from_rs_ex), .rob_id_from_rs_ex(rob_id_from_rs_ex),
    .data_from_rs_ex(data_from_rs_ex), .valid_sign_from_ls_ex(valid_sign_from_ls_ex),
    .rob_id_from_ls_ex(rob_id_from_ls_ex), .data_from_ls_ex(data_from_ls_ex),
    .full_sign_from_ls_ex(full_sign_from_ls_ex), .enable_sign_to_ls_ex(enable_sign_to_ls_ex),
    .opnum_to_ls_ex(opnum_to_ls_ex), .address_to_ls_ex(address_to_ls_ex),
    .store_data_to_ls_ex(store_data_to_ls_ex), .rob_id(rob_id), .full_sign_to_fch(full_sign_to_fch)
  );

  // ---------------- reference model ----------------
  typedef struct {
    bit               is_store;
    bit               committed;
    logic [OPW-1:0]   opnum;
    logic [XLEN-1:0]  v1, v2, imm;
    logic [ROB_W-1:0] q1, q2, rob;
  } m_entry_t;

  m_entry_t m_q[$];
  int m_head;
  logic exp_en;
  logic [OPW-1:0] exp_op;
  logic [XLEN-1:0] exp_addr, exp_sdata;
  logic [ROB_W-1:0] exp_rob;

  function automatic int m_tail();
    return (m_head + m_q.size()) % DEPTH;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_head = 0;
    exp_en = 0; exp_op = '0; exp_addr = '0; exp_sdata = '0; exp_rob = '0;
  endfunction

  function automatic m_entry_t m_wake(m_entry_t e);
    if (valid_sign_from_rs_ex && rob_id_from_rs_ex != 0 && e.q1 == rob_id_from_rs_ex) begin e.v1 = data_from_rs_ex; e.q1 = 0; end
    if (valid_sign_from_ls_ex && rob_id_from_ls_ex != 0 && e.q1 == rob_id_from_ls_ex) begin e.v1 = data_from_ls_ex; e.q1 = 0; end
    if (valid_sign_from_rs_ex && rob_id_from_rs_ex != 0 && e.q2 == rob_id_from_rs_ex) begin e.v2 = data_from_rs_ex; e.q2 = 0; end
    if (valid_sign_from_ls_ex && rob_id_from_ls_ex != 0 && e.q2 == rob_id_from_ls_ex) begin e.v2 = data_from_ls_ex; e.q2 = 0; end
    return e;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    m_entry_t kept[$];
    m_entry_t e;
    bit iss, enq;
    if (!rdy) return;
    exp_en = 0;
    if (rollback_sign_from_rob) begin
      foreach (m_q[i]) if (m_q[i].committed) kept.push_back(m_q[i]);
      m_q = kept;
      return;
    end
    iss = (m_q.size() > 0) && !full_sign_from_ls_ex && m_q[0].q1 == 0 &&
          (!m_q[0].is_store || (m_q[0].q2 == 0 && m_q[0].committed));
    enq = enable_sign_from_cmd && (m_q.size() < DEPTH);
    if (iss) begin
      exp_en = 1; exp_op = m_q[0].opnum; exp_addr = m_q[0].v1 + m_q[0].imm;
      exp_sdata = m_q[0].v2; exp_rob = m_q[0].rob;
      void'(m_q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    foreach (m_q[i]) begin
      e = m_wake(m_q[i]);
      if (commit_sign_from_rob && e.is_store && e.rob == rob_id_from_rob) e.committed = 1;
      m_q[i] = e;
    end
    if (enq) begin
      e.is_store = is_store_from_cmd; e.committed = 0; e.opnum = opnum_from_cmd;
      e.v1 = V1_from_cmd; e.v2 = V2_from_cmd; e.imm = imm_from_cmd;
      e.q1 = Q1_from_cmd; e.q2 = Q2_from_cmd; e.rob = rob_id_from_cmd;
      m_q.push_back(m_wake(e));
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    rdy = 1; enable_sign_from_cmd = 0; opnum_from_cmd = '0; is_store_from_cmd = 0;
    V1_from_cmd = '0; V2_from_cmd = '0; imm_from_cmd = '0; Q1_from_cmd = '0; Q2_from_cmd = '0;
    rob_id_from_cmd = '0; rollback_sign_from_rob = 0; commit_sign_from_rob = 0; rob_id_from_rob = '0;
    valid_sign_from_rs_ex = 0; rob_id_from_rs_ex = '0; data_from_rs_ex = '0;
    valid_sign_from_ls_ex = 0; rob_id_from_ls_ex = '0; data_from_ls_ex = '0; full_sign_from_ls_ex = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input bit st, input logic [XLEN-1:0] v1, input logic [XLEN-1:0] imm,
                           input logic [XLEN-1:0] v2, input logic [ROB_W-1:0] q1,
                           input logic [ROB_W-1:0] q2, input logic [ROB_W-1:0] rid);
    enable_sign_from_cmd = 1; is_store_from_cmd = st; opnum_from_cmd = st ? 6'h08 : 6'h03;
    V1_from_cmd = v1; imm_from_cmd = imm; V2_from_cmd = v2;
    Q1_from_cmd = q1; Q2_from_cmd = q2; rob_id_from_cmd = rid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    rst = 0;
    #2;
    checks++; if (enable_sign_to_ls_ex !== 1'b0) begin failures++; $display("FAIL reset_enable got=%0h exp=0", enable_sign_to_ls_ex); end
    checks++; if (address_to_ls_ex !== '0) begin failures++; $display("FAIL reset_address got=%0h exp=0", address_to_ls_ex); end
    checks++; if (full_sign_to_fch !== 1'b0) begin failures++; $display("FAIL reset_full got=%0h exp=0", full_sign_to_fch); end
    checks++; if (dut.count_q !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut.count_q); end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    m_reset();
  endtask

  task automatic test_load_issue();
    set_idle();
    drive_enq(0, 32'h1000, 32'h10, 32'h0, 0, 0, 3);
    tick();
    set_idle();
    tick();
    checks++; if (enable_sign_to_ls_ex !== 1'b1) begin failures++; $display("FAIL load_enable got=%0h exp=1", enable_sign_to_ls_ex); end
    checks++; if (address_to_ls_ex !== 32'h1010) begin failures++; $display("FAIL load_address got=%0h exp=1010", address_to_ls_ex); end
    checks++; if (rob_id !== 4'd3) begin failures++; $display("FAIL load_rob got=%0d exp=3", rob_id); end
    tick();
    checks++; if (enable_sign_to_ls_ex !== 1'b0) begin failures++; $display("FAIL load_single_pulse got=%0h exp=0", enable_sign_to_ls_ex); end
    checks++; if (address_to_ls_ex !== 32'h1010) begin failures++; $display("FAIL load_addr_hold got=%0h exp=1010", address_to_ls_ex); end
  endtask

  task automatic test_store_wakeup();
    set_idle();
    drive_enq(1, 32'h2000, 32'h4, 32'h0, 0, 5, 4);
    tick();
    set_idle();
    valid_sign_from_rs_ex = 1; rob_id_from_rs_ex = 5; data_from_rs_ex = 32'hDEAD;
    tick();
    set_idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (enable_sign_to_ls_ex !== 1'b0) begin failures++; $display("FAIL store_before_commit cyc=%0d got=%0h exp=0", i, enable_sign_to_ls_ex); end
    end
    commit_sign_from_rob = 1; rob_id_from_rob = 4;
    tick();
    checks++; if (enable_sign_to_ls_ex !== 1'b0) begin failures++; $display("FAIL store_commit_cycle got=%0h exp=0", enable_sign_to_ls_ex); end
    set_idle();
    tick();
    checks++; if (enable_sign_to_ls_ex !== 1'b1) begin failures++; $display("FAIL store_enable got=%0h exp=1", enable_sign_to_ls_ex); end
    checks++; if (store_data_to_ls_ex !== 32'hDEAD) begin failures++; $display("FAIL store_data got=%0h exp=dead", store_data_to_ls_ex); end
    checks++; if (address_to_ls_ex !== 32'h2004) begin failures++; $display("FAIL store_address got=%0h exp=2004", address_to_ls_ex); end
    checks++; if (rob_id !== 4'd4) begin failures++; $display("FAIL store_rob got=%0d exp=4", rob_id); end
    tick();
  endtask

  task automatic test_full();
    int exp_cnt;
    set_idle();
    full_sign_from_ls_ex = 1;
    for (int k = 1; k <= 17; k++) begin
      drive_enq(0, 32'h100 * k, 0, 0, 0, 0, ROB_W'((k % 15) + 1));
      tick();
      exp_cnt = (k > DEPTH) ? DEPTH : k;
      checks++; if (dut.count_q !== exp_cnt) begin failures++; $display("FAIL full_count k=%0d got=%0d exp=%0d", k, dut.count_q, exp_cnt); end
      checks++; if (full_sign_to_fch !== (exp_cnt >= DEPTH - FULL_MARGIN)) begin failures++; $display("FAIL full_flag k=%0d got=%0h", k, full_sign_to_fch); end
      checks++; if (dut.tail_q !== m_tail()) begin failures++; $display("FAIL full_tail k=%0d got=%0d exp=%0d", k, dut.tail_q, m_tail()); end
    end
    full_sign_from_ls_ex = 0;
    tick();
    checks++; if (dut.count_q !== DEPTH - 1) begin failures++; $display("FAIL full_enq_issue_drop got=%0d exp=%0d", dut.count_q, DEPTH - 1); end
    checks++; if (enable_sign_to_ls_ex !== 1'b1) begin failures++; $display("FAIL full_issue got=%0h exp=1", enable_sign_to_ls_ex); end
    set_idle();
    full_sign_from_ls_ex = 1;
    rollback_sign_from_rob = 1;
    tick();
    checks++; if (dut.count_q !== 0) begin failures++; $display("FAIL full_rollback_count got=%0d exp=0", dut.count_q); end
    checks++; if (enable_sign_to_ls_ex !== 1'b0) begin failures++; $display("FAIL full_rollback_enable got=%0h exp=0", enable_sign_to_ls_ex); end
    set_idle();
    tick();
  endtask

  task automatic test_rollback();
    int pulses = 0;
    logic [ROB_W-1:0] want_rob[2] = '{4'd1, 4'd2};
    logic [XLEN-1:0] want_data[2] = '{32'h11, 32'h22};
    set_idle(); full_sign_from_ls_ex = 1;
    drive_enq(1, 32'h3000, 0, 32'h11, 0, 0, 1); tick();
    drive_enq(1, 32'h3004, 0, 32'h22, 0, 0, 2); tick();
    set_idle(); full_sign_from_ls_ex = 1;
    commit_sign_from_rob = 1; rob_id_from_rob = 1; tick();
    rob_id_from_rob = 2; tick();
    set_idle(); full_sign_from_ls_ex = 1;
    for (int i = 0; i < 3; i++) begin drive_enq(0, 32'h4000, 0, 0, 0, 0, ROB_W'(i + 3)); tick(); end
    set_idle(); full_sign_from_ls_ex = 1;
    rollback_sign_from_rob = 1;
    drive_enq(0, 32'h5000, 0, 0, 0, 0, 9);
    tick();
    checks++; if (dut.count_q !== 2) begin failures++; $display("FAIL rb_count got=%0d exp=2", dut.count_q); end
    checks++; if (dut.tail_q !== (m_head + 2) % DEPTH) begin failures++; $display("FAIL rb_tail got=%0d exp=%0d", dut.tail_q, (m_head + 2) % DEPTH); end
    checks++; if (enable_sign_to_ls_ex !== 1'b0) begin failures++; $display("FAIL rb_enable got=%0h exp=0", enable_sign_to_ls_ex); end
    set_idle();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (enable_sign_to_ls_ex === 1'b1) begin
        if (pulses < 2) begin
          checks++; if (rob_id !== want_rob[pulses]) begin failures++; $display("FAIL rb_issue_rob n=%0d got=%0d exp=%0d", pulses, rob_id, want_rob[pulses]); end
          checks++; if (store_data_to_ls_ex !== want_data[pulses]) begin failures++; $display("FAIL rb_issue_data n=%0d got=%0h exp=%0h", pulses, store_data_to_ls_ex, want_data[pulses]); end
        end
        pulses++;
      end
    end
    checks++; if (pulses !== 2) begin failures++; $display("FAIL rb_pulse_count got=%0d exp=2", pulses); end
    checks++; if (dut.count_q !== 0) begin failures++; $display("FAIL rb_drained got=%0d exp=0", dut.count_q); end
  endtask

  task automatic test_wrap_backpressure();
    int prev_tail;
    set_idle();
    for (int i = 0; i < 20; i++) begin
      prev_tail = m_tail();
      drive_enq(0, 32'h20 * i, 0, 0, 0, 0, ROB_W'((i % 15) + 1));
      tick();
      checks++; if (dut.tail_q !== m_tail()) begin failures++; $display("FAIL wrap_tail i=%0d got=%0d exp=%0d", i, dut.tail_q, m_tail()); end
      if (prev_tail == DEPTH - 1) begin
        checks++; if (dut.tail_q !== 0) begin failures++; $display("FAIL wrap_to_zero got=%0d exp=0", dut.tail_q); end
      end
    end
    set_idle();
    repeat (3) tick();
    full_sign_from_ls_ex = 1;
    drive_enq(0, 32'h40, 32'h4, 0, 0, 0, 7);
    tick();
    set_idle(); full_sign_from_ls_ex = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (enable_sign_to_ls_ex !== 1'b0) begin failures++; $display("FAIL bp_hold cyc=%0d got=%0h exp=0", i, enable_sign_to_ls_ex); end
    end
    full_sign_from_ls_ex = 0;
    tick();
    checks++; if (enable_sign_to_ls_ex !== 1'b1) begin failures++; $display("FAIL bp_release got=%0h exp=1", enable_sign_to_ls_ex); end
    checks++; if (address_to_ls_ex !== 32'h44) begin failures++; $display("FAIL bp_address got=%0h exp=44", address_to_ls_ex); end
    tick();
  endtask

  task automatic test_reset_mid_issue();
    set_idle();
    drive_enq(0, 32'h500, 32'h8, 0, 0, 0, 9);
    tick();
    set_idle();
    drive_enq(0, 32'h700, 0, 0, 0, 0, 11);
    tick();
    checks++; if (enable_sign_to_ls_ex !== 1'b1) begin failures++; $display("FAIL mid_pre_enable got=%0h exp=1", enable_sign_to_ls_ex); end
    #1 rst = 0;
    #1;
    checks++; if (enable_sign_to_ls_ex !== 1'b0) begin failures++; $display("FAIL mid_rst_enable got=%0h exp=0", enable_sign_to_ls_ex); end
    checks++; if (address_to_ls_ex !== '0 || rob_id !== '0 || opnum_to_ls_ex !== '0 || store_data_to_ls_ex !== '0) begin
      failures++; $display("FAIL mid_rst_outputs addr=%0h rob=%0d op=%0h sd=%0h exp=all0", address_to_ls_ex, rob_id, opnum_to_ls_ex, store_data_to_ls_ex); end
    checks++; if (dut.count_q !== 0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", dut.count_q); end
    m_reset();
    set_idle();
    @(posedge clk);
    #1 rst = 1;
    drive_enq(0, 32'h600, 0, 0, 0, 0, 10);
    tick();
    checks++; if (dut.tail_q !== 1) begin failures++; $display("FAIL mid_first_slot tail got=%0d exp=1", dut.tail_q); end
    set_idle();
    tick();
    checks++; if (enable_sign_to_ls_ex !== 1'b1 || rob_id !== 4'd10 || address_to_ls_ex !== 32'h600) begin
      failures++; $display("FAIL mid_after_release en=%0h rob=%0d addr=%0h exp=1/10/600", enable_sign_to_ls_ex, rob_id, address_to_ls_ex); end
  endtask

  task automatic test_random();
    int next_rob = 1;
    int cand;
    bit dup;
    for (int c = 0; c < 400; c++) begin
      set_idle();
      rdy = ($urandom_range(0, 9) != 0);
      rollback_sign_from_rob = ($urandom_range(0, 39) == 0);
      full_sign_from_ls_ex = ($urandom_range(0, 3) == 0);
      if (m_q.size() < 14 && $urandom_range(0, 1) == 1) begin
        drive_enq($urandom_range(0, 1), $urandom, $urandom_range(0, 255), $urandom,
                  ($urandom_range(0, 2) == 0) ? ROB_W'($urandom_range(1, 15)) : '0,
                  ($urandom_range(0, 2) == 0) ? ROB_W'($urandom_range(1, 15)) : '0, ROB_W'(next_rob));
        if (rdy && !rollback_sign_from_rob) next_rob = (next_rob % 15) + 1;
      end
      valid_sign_from_rs_ex = ($urandom_range(0, 9) < 4);
      rob_id_from_rs_ex = ROB_W'($urandom_range(1, 15)); data_from_rs_ex = $urandom;
      valid_sign_from_ls_ex = ($urandom_range(0, 9) < 3);
      rob_id_from_ls_ex = ROB_W'($urandom_range(1, 15)); data_from_ls_ex = $urandom;
      if (rob_id_from_ls_ex == rob_id_from_rs_ex) rob_id_from_ls_ex = ROB_W'((rob_id_from_ls_ex % 15) + 1);
      // commit only the oldest uncommitted store, and only when every older entry is a committed store
      cand = -1;
      foreach (m_q[i]) begin
        if (m_q[i].is_store && m_q[i].committed) continue;
        if (m_q[i].is_store) cand = i;
        break;
      end
      if (cand >= 0 && !rollback_sign_from_rob && $urandom_range(0, 1) == 1) begin
        dup = 0;
        foreach (m_q[i]) if (i != cand && m_q[i].is_store && m_q[i].rob == m_q[cand].rob) dup = 1;
        if (!dup) begin commit_sign_from_rob = 1; rob_id_from_rob = m_q[cand].rob; end
      end
      tick();
      checks++; if (enable_sign_to_ls_ex !== exp_en) begin failures++; $display("FAIL rnd_enable c=%0d got=%0h exp=%0h", c, enable_sign_to_ls_ex, exp_en); end
      checks++; if (address_to_ls_ex !== exp_addr) begin failures++; $display("FAIL rnd_address c=%0d got=%0h exp=%0h", c, address_to_ls_ex, exp_addr); end
      checks++; if (store_data_to_ls_ex !== exp_sdata) begin failures++; $display("FAIL rnd_sdata c=%0d got=%0h exp=%0h", c, store_data_to_ls_ex, exp_sdata); end
      checks++; if (opnum_to_ls_ex !== exp_op || rob_id !== exp_rob) begin failures++; $display("FAIL rnd_op_rob c=%0d got=%0h/%0d exp=%0h/%0d", c, opnum_to_ls_ex, rob_id, exp_op, exp_rob); end
      checks++; if (full_sign_to_fch !== (m_q.size() >= DEPTH - FULL_MARGIN)) begin failures++; $display("FAIL rnd_full c=%0d got=%0h size=%0d", c, full_sign_to_fch, m_q.size()); end
      checks++; if (dut.count_q !== m_q.size()) begin failures++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, dut.count_q, m_q.size()); end
      checks++; if (dut.tail_q !== m_tail()) begin failures++; $display("FAIL rnd_tail c=%0d got=%0d exp=%0d", c, dut.tail_q, m_tail()); end
    end
  endtask

  initial begin
    test_reset();
    test_load_issue();
    test_store_wakeup();
    test_full();
    test_rollback();
    test_wrap_backpressure();
    test_reset_mid_issue();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
